// File: rtl/wtm32_seq_ctrl_if.sv
// Bundles the multiply request/response signals with the external WTM8 slice port.
// slave is the controller's view; master is the requester and slice-multiplier side.
interface wtm32_seq_ctrl_if;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [63:0] Result;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] mul_p;
  logic        mul_valid;

  modport master (
    output start, A, B, mul_p,
    input  busy, done, Result, mul_a, mul_b, mul_valid
  );

  modport slave (
    input  start, A, B, mul_p,
    output busy, done, Result, mul_a, mul_b, mul_valid
  );
endinterface

// File: rtl/wtm32_seq_ctrl.sv
// Iterative 32x32 unsigned multiplier that steps one external 8x8 slice through the
// byte-pair partial products, shifting and accumulating each into a 64-bit sum.
module wtm32_seq_ctrl #(
  parameter bit EARLY_OUT = 1'b0
) (
  input logic            clk,
  input logic            rst,
  wtm32_seq_ctrl_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q;
  logic [31:0] opa_q;
  logic [31:0] opb_q;
  logic [63:0] acc_q;
  logic [63:0] result_q;
  logic [1:0]  j_q;
  logic [1:0]  k_q;
  logic [2:0]  nb_q;
  logic        busy_q;
  logic        done_q;

  logic [2:0]  nb_start;
  logic [31:0] opa_sh;
  logic [31:0] opb_sh;
  logic [7:0]  mul_a_c;
  logic [7:0]  mul_b_c;
  logic [2:0]  jk_sum;
  logic [5:0]  shamt;
  logic [63:0] term;
  logic [63:0] acc_sum;
  logic        k_last;
  logic        last;

  // Multiplier bytes above the highest nonzero one contribute nothing, so they can be skipped.
  always_comb begin
    nb_start = 3'd4;
    if (EARLY_OUT) begin
      if (bus.B[31:24] != 8'd0) begin
        nb_start = 3'd4;
      end else if (bus.B[23:16] != 8'd0) begin
        nb_start = 3'd3;
      end else if (bus.B[15:8] != 8'd0) begin
        nb_start = 3'd2;
      end else begin
        nb_start = 3'd1;
      end
    end
  end

  always_comb begin
    opa_sh  = opa_q >> {j_q, 3'b000};
    opb_sh  = opb_q >> {k_q, 3'b000};
    mul_a_c = 8'd0;
    mul_b_c = 8'd0;
    if (state_q == StRun) begin
      mul_a_c = opa_sh[7:0];
      mul_b_c = opb_sh[7:0];
    end
  end

  always_comb begin
    jk_sum  = {1'b0, j_q} + {1'b0, k_q};
    shamt   = {jk_sum, 3'b000};
    term    = {48'd0, bus.mul_p} << shamt;
    acc_sum = acc_q + term;
    k_last  = ({1'b0, k_q} == (nb_q - 3'd1));
    last    = (j_q == 2'd3) && k_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      j_q      <= '0;
      k_q      <= '0;
      nb_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            opa_q   <= bus.A;
            opb_q   <= bus.B;
            acc_q   <= '0;
            j_q     <= '0;
            k_q     <= '0;
            nb_q    <= nb_start;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          acc_q <= acc_sum;
          if (last) begin
            result_q <= acc_sum;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= StIdle;
          end else if (k_last) begin
            k_q <= '0;
            j_q <= j_q + 2'd1;
          end else begin
            k_q <= k_q + 2'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.Result    = result_q;
  assign bus.mul_a     = mul_a_c;
  assign bus.mul_b     = mul_b_c;
  // RUN and busy coincide, so the accumulate strobe is just the busy flag.
  assign bus.mul_valid = busy_q;

endmodule

// File: tb/tb_wtm32_seq_ctrl.sv
// Bench for wtm32_seq_ctrl: two instances (EARLY_OUT=0 and 1) share stimulus, each with a
// behavioural WTM8, checked every cycle against an operation-level model plus literal vectors.
module tb_wtm32_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a_in;
  logic [31:0] b_in;

  always #5 clk = ~clk;

  wtm32_seq_ctrl_if if0 ();
  wtm32_seq_ctrl_if if1 ();

  assign if0.start = start;
  assign if0.A     = a_in;
  assign if0.B     = b_in;
  assign if0.mul_p = {8'd0, if0.mul_a} * {8'd0, if0.mul_b};
  assign if1.start = start;
  assign if1.A     = a_in;
  assign if1.B     = b_in;
  assign if1.mul_p = {8'd0, if1.mul_a} * {8'd0, if1.mul_b};

  wtm32_seq_ctrl #(.EARLY_OUT(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  wtm32_seq_ctrl #(.EARLY_OUT(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  logic        busy_w  [2];
  logic        done_w  [2];
  logic        valid_w [2];
  logic [63:0] res_w   [2];
  logic [7:0]  ma_w    [2];
  logic [7:0]  mb_w    [2];

  assign busy_w[0]  = if0.busy;
  assign busy_w[1]  = if1.busy;
  assign done_w[0]  = if0.done;
  assign done_w[1]  = if1.done;
  assign valid_w[0] = if0.mul_valid;
  assign valid_w[1] = if1.mul_valid;
  assign res_w[0]   = if0.Result;
  assign res_w[1]   = if1.Result;
  assign ma_w[0]    = if0.mul_a;
  assign ma_w[1]    = if1.mul_a;
  assign mb_w[0]    = if0.mul_b;
  assign mb_w[1]    = if1.mul_b;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Operation-level model: an accepted start yields A*B after 4*nb cycles.
  bit          m_busy [2];
  bit          m_done [2];
  int          m_cnt  [2];
  int          m_nb   [2];
  logic [31:0] m_a    [2];
  logic [31:0] m_b    [2];
  logic [63:0] m_res  [2];

  function automatic int nb_of(input int d, input logic [31:0] b);
    if (d == 0) return 4;
    if (b[31:24] != 8'd0) return 4;
    if (b[23:16] != 8'd0) return 3;
    if (b[15:8] != 8'd0) return 2;
    return 1;
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int idx);
    logic [31:0] s;
    s = w >> (8 * idx);
    return s[7:0];
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_busy[d] <= 1'b0;
        m_done[d] <= 1'b0;
        m_cnt[d]  <= 0;
        m_nb[d]   <= 4;
        m_res[d]  <= 64'd0;
        m_a[d]    <= 32'd0;
        m_b[d]    <= 32'd0;
      end else begin
        m_done[d] <= 1'b0;
        if (m_busy[d]) begin
          m_cnt[d] <= m_cnt[d] + 1;
          if (m_cnt[d] + 1 == 4 * m_nb[d]) begin
            m_busy[d] <= 1'b0;
            m_done[d] <= 1'b1;
            m_res[d]  <= {32'd0, m_a[d]} * {32'd0, m_b[d]};
          end
        end else if (start) begin
          m_busy[d] <= 1'b1;
          m_cnt[d]  <= 0;
          m_a[d]    <= a_in;
          m_b[d]    <= b_in;
          m_nb[d]   <= nb_of(d, b_in);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("dut%0d busy", d), 64'(busy_w[d]), 64'(m_busy[d]));
        check($sformatf("dut%0d done", d), 64'(done_w[d]), 64'(m_done[d]));
        check($sformatf("dut%0d Result", d), res_w[d], m_res[d]);
        check($sformatf("dut%0d mul_valid", d), 64'(valid_w[d]), 64'(m_busy[d]));
        check($sformatf("dut%0d mul_a", d), 64'(ma_w[d]),
              m_busy[d] ? 64'(byte_of(m_a[d], m_cnt[d] / m_nb[d])) : 64'd0);
        check($sformatf("dut%0d mul_b", d), 64'(mb_w[d]),
              m_busy[d] ? 64'(byte_of(m_b[d], m_cnt[d] % m_nb[d])) : 64'd0);
      end
    end
  end

  task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] r0, output logic [63:0] r1,
                        output int lat0, output int lat1, output int vc0, output int vc1);
    lat0 = -1; lat1 = -1; vc0 = 0; vc1 = 0; r0 = 'x; r1 = 'x;
    @(negedge clk);
    start = 1'b1; a_in = a; b_in = b;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n <= 40; n++) begin
      if (n > 0) @(negedge clk);
      if (lat0 < 0 && valid_w[0]) vc0++;
      if (lat1 < 0 && valid_w[1]) vc1++;
      if (lat0 < 0 && done_w[0]) begin lat0 = n; r0 = res_w[0]; end
      if (lat1 < 0 && done_w[1]) begin lat1 = n; r1 = res_w[1]; end
      if (lat0 >= 0 && lat1 >= 0) break;
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] r;
    int          lat1;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [63:0] r0, r1, rf, rs;
    int lat0, lat1, vc0, vc1, dn0, dn1, first0, second0;
    bit busy_ok;

    vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 16};
    vecs[1] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 12};
    vecs[2] = '{32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, 4};
    vecs[3] = '{32'h0000_00FF, 32'h0000_0100, 64'h0000_0000_0000_FF00, 8};
    vecs[4] = '{32'h0000_0005, 32'h0000_0003, 64'd15, 4};
    vecs[5] = '{32'h0000_0010, 32'h0100_0000, 64'h0000_0000_1000_0000, 16};

    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset dut%0d busy", d), 64'(busy_w[d]), 64'd0);
      check($sformatf("reset dut%0d done", d), 64'(done_w[d]), 64'd0);
      check($sformatf("reset dut%0d Result", d), res_w[d], 64'd0);
      check($sformatf("reset dut%0d mul_valid", d), 64'(valid_w[d]), 64'd0);
    end

    foreach (vecs[i]) begin
      do_mul(vecs[i].a, vecs[i].b, r0, r1, lat0, lat1, vc0, vc1);
      check($sformatf("vec%0d dut0 Result", i), r0, vecs[i].r);
      check($sformatf("vec%0d dut1 Result", i), r1, vecs[i].r);
      check($sformatf("vec%0d dut0 latency", i), 64'(lat0), 64'd16);
      check($sformatf("vec%0d dut1 latency", i), 64'(lat1), 64'(vecs[i].lat1));
      check($sformatf("vec%0d dut0 valid cycles", i), 64'(vc0), 64'd16);
      check($sformatf("vec%0d dut1 valid cycles", i), 64'(vc1), 64'(vecs[i].lat1));
    end

    // Second start while dut0 is busy must be dropped; dut1 is already idle and takes it.
    dn0 = 0; dn1 = 0; busy_ok = 1'b1; r0 = '0; r1 = '0;
    @(negedge clk);
    start = 1'b1; a_in = 32'd5; b_in = 32'd3;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 5) begin start = 1'b1; a_in = 32'd7; b_in = 32'd9; end
      if (n == 6) start = 1'b0;
      if (n < 16 && !busy_w[0]) busy_ok = 1'b0;
      if (done_w[0]) begin dn0++; r0 = res_w[0]; end
      if (done_w[1]) begin dn1++; r1 = res_w[1]; end
    end
    check("ignore dut0 done count", 64'(dn0), 64'd1);
    check("ignore dut0 Result", r0, 64'd15);
    check("ignore dut0 busy held", 64'(busy_ok), 64'd1);
    check("ignore dut1 done count", 64'(dn1), 64'd2);
    check("ignore dut1 Result", r1, 64'd63);

    // Start presented in the done cycle is taken immediately.
    first0 = -1; second0 = -1; rf = '0; rs = '0;
    @(negedge clk);
    start = 1'b1; a_in = 32'h0000_1234; b_in = 32'h0000_5678;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (n > 0) @(negedge clk);
      if (first0 >= 0 && n == first0 + 1) start = 1'b0;
      if (done_w[0]) begin
        if (first0 < 0) begin
          first0 = n; rf = res_w[0];
          start = 1'b1; a_in = 32'hDEAD_BEEF; b_in = 32'h0000_0010;
        end else begin
          second0 = n; rs = res_w[0];
        end
      end
      if (second0 >= 0) break;
    end
    start = 1'b0;
    check("b2b first latency", 64'(first0), 64'd16);
    check("b2b first Result", rf, 64'h0000_0000_0626_0060);
    check("b2b second latency", 64'(second0), 64'd33);
    check("b2b second Result", rs, 64'h0000_000D_EADB_EEF0);
    repeat (6) @(negedge clk);

    // Reset in the middle of an operation.
    @(negedge clk);
    start = 1'b1; a_in = 32'h0000_FFFF; b_in = 32'hFFFF_0000;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("midrst dut%0d busy", d), 64'(busy_w[d]), 64'd0);
      check($sformatf("midrst dut%0d done", d), 64'(done_w[d]), 64'd0);
      check($sformatf("midrst dut%0d Result", d), res_w[d], 64'd0);
      check($sformatf("midrst dut%0d mul_valid", d), 64'(valid_w[d]), 64'd0);
    end
    dn0 = 0; dn1 = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done_w[0]) dn0++;
      if (done_w[1]) dn1++;
    end
    check("midrst dut0 no done", 64'(dn0), 64'd0);
    check("midrst dut1 no done", 64'(dn1), 64'd0);
    do_mul(32'd2, 32'd3, r0, r1, lat0, lat1, vc0, vc1);
    check("post-rst dut0 Result", r0, 64'd6);
    check("post-rst dut1 Result", r1, 64'd6);
    check("post-rst dut0 latency", 64'(lat0), 64'd16);
    check("post-rst dut1 latency", 64'(lat1), 64'd4);

    repeat (4) @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
